// File: rtl/cv32e40x_fencei_flush_ctrl.sv
// fence.i flush sequencer: drains the data side, waits a settle window, then runs the
// external flush req/ack handshake and returns a one-cycle ack to the controller.
module cv32e40x_fencei_flush_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fencei_flush_req_i,
    output logic                 fencei_flush_ack_o,
    input  logic                 lsu_busy_i,
    input  logic                 wbuf_empty_i,
    output logic                 flush_req_o,
    input  logic                 flush_ack_i,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRAIN  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] REQ    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0]        tmo_cnt_inc;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 drained;

    assign drained = !lsu_busy_i && wbuf_empty_i;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE: begin
                if (fencei_flush_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            SETTLE: begin
                if (!drained) begin
                    state_d = DRAIN;
                end else if (settle_cnt_q == '0) begin
                    state_d = REQ;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            REQ: begin
                if (flush_ack_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Watchdog only counts REQ cycles still waiting for ack; it restarts on each REQ entry.
    assign tmo_cnt_inc = (tmo_cnt_q == TIMEOUT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    always_comb begin
        tmo_cnt_d = '0;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE && fencei_flush_req_i) begin
            timeout_d = 1'b0;
        end
        if (state_q == REQ) begin
            tmo_cnt_d = tmo_cnt_q;
            if (flush_ack_i) begin
                cnt_d = cnt_q + 1'b1;
            end else if (TIMEOUT_CYCLES > 0) begin
                tmo_cnt_d = tmo_cnt_inc;
                if (tmo_cnt_inc == TIMEOUT_MAX) timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign flush_req_o        = (state_q == REQ);
    assign fencei_flush_ack_o = (state_q == DONE);
    assign busy_o             = (state_q != IDLE);
    assign timeout_o          = timeout_q;
    assign flush_cnt_o        = cnt_q;

`ifndef SYNTHESIS
    a_req_dropped_after_ack: assert property (
        @(posedge clk) disable iff (!rst_n) (state_q == DONE) |=> !fencei_flush_req_i
    ) else $error("fencei_flush_req_i still high after fencei_flush_ack_o");

    a_req_held_until_ack: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == DRAIN || state_q == SETTLE || state_q == REQ) |-> fencei_flush_req_i
    ) else $error("fencei_flush_req_i dropped before fencei_flush_ack_o");
`endif

endmodule

// File: tb/tb_cv32e40x_fencei_flush_ctrl.sv
// Randomized bench for cv32e40x_fencei_flush_ctrl; each flush is predicted from event
// times (drain window end, ack cycle) derived from the drive schedule.
module tb_cv32e40x_fencei_flush_ctrl;

    localparam int SETTLE = 2;
    localparam int TMO    = 8;
    localparam int CW     = 2;
    localparam int MAXC   = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fencei_flush_req_i = 1'b0;
    logic          fencei_flush_ack_o;
    logic          lsu_busy_i = 1'b0;
    logic          wbuf_empty_i = 1'b1;
    logic          flush_req_o;
    logic          flush_ack_i = 1'b0;
    logic          busy_o;
    logic          timeout_o;
    logic [CW-1:0] flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state carried between flushes
    int exp_cnt = 0;
    bit exp_to  = 1'b0;

    cv32e40x_fencei_flush_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fencei_flush_req_i(fencei_flush_req_i),
        .fencei_flush_ack_o(fencei_flush_ack_o),
        .lsu_busy_i        (lsu_busy_i),
        .wbuf_empty_i      (wbuf_empty_i),
        .flush_req_o       (flush_req_o),
        .flush_ack_i       (flush_ack_i),
        .busy_o            (busy_o),
        .timeout_o         (timeout_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic drive_drained(input bit dr);
        if (dr) begin
            lsu_busy_i   = 1'b0;
            wbuf_empty_i = 1'b1;
        end else begin
            lsu_busy_i   = 1'($urandom_range(0, 1));
            wbuf_empty_i = lsu_busy_i ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    // Cycle 0 is the IDLE cycle in which req_i is first sampled. Expected outputs:
    // req_o on [r, a], ack_o at a+1, count bumps at a+1, timeout from r+TMO if a >= r+TMO.
    task automatic run_flush(input int busy_len, input int hole, input int delay,
                             input bit noise, input int rst_off);
        bit d[MAXC];
        int r, a, run, cnt0;
        bit to0, e_req, e_ack, e_busy, e_to;
        int e_cnt;
        r = -1;
        run = 0;
        for (int k = 0; k < MAXC; k++) begin
            d[k] = (k > busy_len) && (k != hole) && (!noise || k > 15 || $urandom_range(0, 3) != 0);
        end
        for (int k = 1; k < MAXC; k++) begin
            run = d[k] ? run + 1 : 0;
            if (run == SETTLE + 1) begin
                r = k + 1;
                break;
            end
        end
        a = r + delay;
        if (r < 0 || a + 3 >= MAXC) begin
            $display("FAIL schedule: r=%0d a=%0d out of range", r, a);
            $fatal(1, "bad schedule");
        end
        cnt0 = exp_cnt;
        to0  = exp_to;
        for (int k = 0; k <= a + 2; k++) begin
            @(negedge clk);
            e_req  = (k >= r) && (k <= a);
            e_ack  = (k == a + 1);
            e_busy = (k >= 1) && (k <= a + 1);
            e_cnt  = (k >= a + 1) ? (cnt0 + 1) % (1 << CW) : cnt0;
            e_to   = (k == 0) ? to0 : ((a >= r + TMO) && (k >= r + TMO));
            n_checks += 5;
            if (flush_req_o !== e_req) begin
                n_fail++;
                $display("FAIL flush_req_o k=%0d: got %b expected %b", k, flush_req_o, e_req);
            end
            if (fencei_flush_ack_o !== e_ack) begin
                n_fail++;
                $display("FAIL fencei_flush_ack_o k=%0d: got %b expected %b", k,
                         fencei_flush_ack_o, e_ack);
            end
            if (busy_o !== e_busy) begin
                n_fail++;
                $display("FAIL busy_o k=%0d: got %b expected %b", k, busy_o, e_busy);
            end
            if (timeout_o !== e_to) begin
                n_fail++;
                $display("FAIL timeout_o k=%0d: got %b expected %b", k, timeout_o, e_to);
            end
            if (flush_cnt_o !== CW'(e_cnt)) begin
                n_fail++;
                $display("FAIL flush_cnt_o k=%0d: got %0d expected %0d", k, flush_cnt_o, e_cnt);
            end
            if (rst_off >= 0 && k == r + rst_off) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({flush_req_o, fencei_flush_ack_o, busy_o, timeout_o, flush_cnt_o} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: got req=%b ack=%b busy=%b to=%b cnt=%0d expected all 0",
                             flush_req_o, fencei_flush_ack_o, busy_o, timeout_o, flush_cnt_o);
                end
                fencei_flush_req_i = 1'b0;
                flush_ack_i        = 1'b0;
                exp_cnt            = 0;
                exp_to             = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            fencei_flush_req_i = (k <= a + 1);
            drive_drained(d[k]);
            if (k == a) flush_ack_i = 1'b1;
            else if (k >= r && k < a) flush_ack_i = 1'b0;
            else flush_ack_i = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        flush_ack_i = 1'b0;
        exp_cnt = (cnt0 + 1) % (1 << CW);
        exp_to  = (a >= r + TMO);
    endtask

    task automatic test_reset();
        #1;
        n_checks += 5;
        if (flush_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_o: got %b expected 0", flush_req_o); end
        if (fencei_flush_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack_o: got %b expected 0", fencei_flush_ack_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_o: got %b expected 0", busy_o); end
        if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_o: got %b expected 0", timeout_o); end
        if (flush_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", flush_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_flush(0, -1, 0, 1'b0, -1);
    endtask

    task automatic test_lsu_busy();
        run_flush(10, -1, 0, 1'b0, -1);
    endtask

    task automatic test_settle_drop();
        run_flush(0, 3, 1, 1'b0, -1);
        run_flush(0, 2, 0, 1'b0, -1);
    endtask

    task automatic test_timeout();
        run_flush(0, -1, 20, 1'b0, -1);
        run_flush(0, -1, TMO - 1, 1'b0, -1);
        run_flush(0, -1, TMO, 1'b0, -1);
        run_flush(0, -1, 0, 1'b0, -1);
    endtask

    task automatic test_spurious_ack();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (busy_o !== 1'b0 || flush_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ack_state: got busy=%b req=%b expected 0", busy_o, flush_req_o);
            end
            if (flush_cnt_o !== CW'(exp_cnt)) begin
                n_fail++;
                $display("FAIL idle_ack_cnt: got %0d expected %0d", flush_cnt_o, exp_cnt);
            end
            flush_ack_i = 1'($urandom_range(0, 1));
        end
        flush_ack_i = 1'b0;
        run_flush(3, -1, 2, 1'b1, -1);
    endtask

    task automatic test_reset_mid_req();
        run_flush(0, -1, 20, 1'b0, 10);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) run_flush(0, -1, i, 1'b0, -1);
        @(negedge clk);
        n_checks++;
        if (flush_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d expected 1", flush_cnt_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_flush($urandom_range(0, 12), $urandom_range(1, 10), $urandom_range(0, 14),
                      1'b1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsu_busy();
        test_settle_drop();
        test_timeout();
        test_spurious_ack();
        test_reset_mid_req();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
